// File: rtl/instr_stream_reader.sv
// Read-side sequencer that walks read_pointer over a block of instruction register entries and streams them out.
// Optional result checker is compiled in when the macro RESULT_CHECK_EN is defined.
package instr_register_pkg;
    typedef enum logic [2:0] {ZERO, PASSA, PASSB, ADD, SUB, MULT, DIV, MOD} opcode_t;
    typedef logic signed [31:0] operand_t;
    typedef logic [4:0]         address_t;
    typedef struct packed {
        opcode_t            opc;
        operand_t           op_a;
        operand_t           op_b;
        logic signed [63:0] result;
    } instruction_t;
endpackage

module instr_stream_reader
    import instr_register_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  address_t         start_addr,
    input  logic [CNT_W-1:0] count,
    output address_t         read_pointer,
    input  instruction_t     instruction_word,
    output logic             out_valid,
    input  logic             out_ready,
    output instruction_t     out_instr,
    output address_t         out_index,
    output logic             busy,
    output logic             done,
    output logic             chk_err,
    output logic [7:0]       err_count
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] remaining;
    logic [CNT_W-1:0] count_clamped;
    address_t         pointer_nxt;
    logic             load;
    logic             xfer;
    logic             finish;

    // Handshake: a word moves when out_valid && out_ready at posedge; while out_valid is high and
    // out_ready is low, out_instr/out_index/chk_err hold. A new word may replace one leaving on the same edge.
    assign xfer          = out_valid && out_ready;
    assign load          = (state == RUN) && (remaining != '0) && (!out_valid || out_ready);
    assign finish        = (state == RUN) && (remaining == '0) && (!out_valid || out_ready);
    assign count_clamped = (count > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : count;
    assign pointer_nxt   = (read_pointer == address_t'(DEPTH - 1)) ? '0 : read_pointer + address_t'(1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (finish) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            read_pointer <= '0;
            remaining    <= '0;
            out_valid    <= 1'b0;
            out_instr    <= '{opc: ZERO, default: '0};
            out_index    <= '0;
            done         <= 1'b0;
        end else begin
            done <= finish;
            if (state == IDLE && start) begin
                read_pointer <= start_addr;
                remaining    <= count_clamped;
            end
            if (load) begin
                out_instr    <= instruction_word;
                out_index    <= read_pointer;
                out_valid    <= 1'b1;
                read_pointer <= pointer_nxt;
                remaining    <= remaining - CNT_W'(1);
            end else if (xfer) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef RESULT_CHECK_EN
    logic signed [63:0] a_ext;
    logic signed [63:0] b_ext;
    logic signed [63:0] expected;
    logic               skip;
    logic               mismatch;

    // Division by zero has no defined result, so those words are never flagged.
    always_comb begin
        a_ext    = {{32{instruction_word.op_a[31]}}, instruction_word.op_a};
        b_ext    = {{32{instruction_word.op_b[31]}}, instruction_word.op_b};
        expected = '0;
        skip     = 1'b0;
        case (instruction_word.opc)
            PASSA:   expected = a_ext;
            PASSB:   expected = b_ext;
            ADD:     expected = a_ext + b_ext;
            SUB:     expected = a_ext - b_ext;
            MULT:    expected = a_ext * b_ext;
            DIV:     if (b_ext == '0) skip = 1'b1; else expected = a_ext / b_ext;
            MOD:     if (b_ext == '0) skip = 1'b1; else expected = a_ext % b_ext;
            default: expected = '0;
        endcase
        mismatch = !skip && (expected != instruction_word.result);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            chk_err   <= 1'b0;
            err_count <= '0;
        end else if (load) begin
            chk_err <= mismatch;
            if (mismatch && err_count != 8'hFF) err_count <= err_count + 8'd1;
        end
    end
`else
    assign chk_err   = 1'b0;
    assign err_count = '0;
`endif

endmodule

// File: tb/tb_instr_stream_reader.sv
// Self-checking bench for instr_stream_reader: random streams against a queue-based reference model.
// Result-checker expectations follow RESULT_CHECK_EN when the bench is compiled with it.
`timescale 1ns/1ps
module tb_instr_stream_reader;
    import instr_register_pkg::*;

    localparam int DEPTH = 32;
    localparam int CNT_W = 6;
    localparam int PW    = 5 + $bits(instruction_t);
    localparam int EW    = PW + 1;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             start = 1'b0;
    address_t         start_addr = '0;
    logic [CNT_W-1:0] count = '0;
    address_t         read_pointer;
    instruction_t     instruction_word;
    logic             out_valid;
    logic             out_ready = 1'b0;
    instruction_t     out_instr;
    address_t         out_index;
    logic             busy;
    logic             done;
    logic             chk_err;
    logic [7:0]       err_count;

    int total = 0;
    int bad = 0;
    int model_err = 0;

    instruction_t   mem [DEPTH];
    logic [EW-1:0]  exp_q [$];
    logic [EW-1:0]  obs_q [$];

    int       first_valid_k, first_xfer_k, last_xfer_k, done_k, stall_bad, stalls;
    address_t rp0, rp_done, rp_after;
    logic     busy0, done_after, busy_after, valid_after;

    instr_stream_reader #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .start_addr(start_addr), .count(count),
        .read_pointer(read_pointer), .instruction_word(instruction_word),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_index(out_index),
        .busy(busy), .done(done), .chk_err(chk_err), .err_count(err_count)
    );

    always #5 clk = ~clk;

    assign instruction_word = mem[read_pointer];

    function automatic longint ref_calc(input instruction_t w, output bit skip);
        longint a, b, r;
        a = longint'(w.op_a);
        b = longint'(w.op_b);
        r = 0;
        skip = 1'b0;
        case (w.opc)
            PASSA: r = a;
            PASSB: r = b;
            ADD:   r = a + b;
            SUB:   r = a - b;
            MULT:  r = a * b;
            DIV:   if (b == 0) skip = 1'b1; else r = a / b;
            MOD:   if (b == 0) skip = 1'b1; else r = a % b;
            default: r = 0;
        endcase
        return r;
    endfunction

    function automatic logic chk_model(input instruction_t w);
`ifdef RESULT_CHECK_EN
        bit     skip;
        longint r;
        r = ref_calc(w, skip);
        return !skip && (r != longint'(w.result));
`else
        return (^w) & 1'b0;
`endif
    endfunction

    function automatic instruction_t make_word(input opcode_t opc, input int a, input int b, input longint res);
        instruction_t w;
        w.opc = opc;
        w.op_a = a;
        w.op_b = b;
        w.result = res;
        return w;
    endfunction

    function automatic instruction_t rand_word();
        instruction_t w;
        bit           skip;
        w = make_word(opcode_t'($urandom_range(0, 7)), int'($urandom_range(0, 200)) - 100,
                      int'($urandom_range(0, 20)) - 10, 0);
        w.result = ($urandom_range(0, 2) == 0) ? longint'($urandom) : ref_calc(w, skip);
        return w;
    endfunction

    task automatic build_expect(input int addr, input int cnt);
        int n, idx;
        exp_q.delete();
        n = (cnt > DEPTH) ? DEPTH : cnt;
        for (int i = 0; i < n; i++) begin
            idx = (addr + i) % DEPTH;
            exp_q.push_back({address_t'(idx), mem[idx], chk_model(mem[idx])});
        end
    endtask

    // Start one stream and record what comes out; mode 0 ready high, 1 random ready, 2 stall index 1 for 3 cycles.
    task automatic run_stream(input int addr, input int cnt, input int mode, input bit poke);
        int            k;
        logic          prev_stall;
        logic [PW-1:0] prev_word;
        build_expect(addr, cnt);
        obs_q.delete();
        first_valid_k = -1; first_xfer_k = -1; last_xfer_k = -1; done_k = -1;
        stall_bad = 0; stalls = 0; prev_stall = 1'b0; prev_word = '0;
        start_addr = address_t'(addr);
        count = CNT_W'(cnt);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        start_addr = address_t'($urandom);
        count = CNT_W'($urandom_range(0, 63));
        k = 0;
        while (done_k < 0 && k < 300) begin
            case (mode)
                0: out_ready = 1'b1;
                1: out_ready = ($urandom_range(0, 3) != 0);
                default: begin
                    out_ready = !(out_valid && out_index == 5'd1 && stalls < 3);
                    if (!out_ready) stalls++;
                end
            endcase
            start = poke && (k == 1 || k == 3);
            @(negedge clk);
            if (k == 0) begin
                rp0 = read_pointer;
                busy0 = busy;
            end
            if (prev_stall && (!out_valid || {out_index, out_instr} !== prev_word)) stall_bad++;
            prev_stall = out_valid && !out_ready;
            prev_word = {out_index, out_instr};
            if (out_valid && first_valid_k < 0) first_valid_k = k;
            if (out_valid && out_ready) begin
                obs_q.push_back({out_index, out_instr, chk_err});
                if (first_xfer_k < 0) first_xfer_k = k;
                last_xfer_k = k;
            end
            if (done) begin
                done_k = k;
                rp_done = read_pointer;
            end
            @(posedge clk); #1;
            start = 1'b0;
            k++;
        end
        out_ready = 1'b0;
        total++;
        if (done_k < 0) begin
            bad++;
            $display("FAIL stream_timeout addr=%0d cnt=%0d got no done within %0d cycles", addr, cnt, k);
        end
        @(negedge clk);
        done_after = done;
        busy_after = busy;
        valid_after = out_valid;
        rp_after = read_pointer;
        @(posedge clk); #1;
        foreach (exp_q[i]) if (exp_q[i][0] && model_err < 255) model_err++;
    endtask

    task automatic test_reset();
        for (int i = 0; i < DEPTH; i++) mem[i] = rand_word();
        mem[0] = make_word(ADD, 5, 3, 8);
        mem[1] = make_word(SUB, 9, 4, 5);
        mem[2] = make_word(MULT, 6, 7, 42);
        mem[3] = make_word(PASSA, 11, 2, 11);
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({read_pointer, out_valid, out_index, busy, done, chk_err, err_count} !== '0) begin
            bad++;
            $display("FAIL reset_ctrl got rp=%0d v=%b idx=%0d busy=%b done=%b chk=%b errs=%0d required all 0",
                     read_pointer, out_valid, out_index, busy, done, chk_err, err_count);
        end
        total++;
        if (out_instr !== '0) begin
            bad++;
            $display("FAIL reset_instr got %h required 0", out_instr);
        end
        reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        run_stream(0, 4, 0, 0);
        total++;
        if (obs_q.size() != 4) begin bad++; $display("FAIL basic_len got %0d required 4", obs_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            total++;
            if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL basic_word%0d got %h required %h", i, obs_q[i], exp_q[i]); end
        end
        total++;
        if (rp0 !== 5'd0 || busy0 !== 1'b1) begin bad++; $display("FAIL basic_start got rp=%0d busy=%b required rp=0 busy=1", rp0, busy0); end
        total++;
        if (first_valid_k != 1) begin bad++; $display("FAIL basic_latency got %0d required 1", first_valid_k); end
        total++;
        if (last_xfer_k - first_xfer_k != 3) begin bad++; $display("FAIL basic_throughput got span %0d required 3", last_xfer_k - first_xfer_k); end
        total++;
        if (done_k != last_xfer_k + 1) begin bad++; $display("FAIL basic_done_time got %0d required %0d", done_k, last_xfer_k + 1); end
        total++;
        if ({done_after, busy_after, valid_after} !== 3'b000) begin
            bad++; $display("FAIL basic_after got done/busy/valid=%b required 000", {done_after, busy_after, valid_after});
        end
        total++;
        if (rp_after !== 5'd4) begin bad++; $display("FAIL basic_rp_idle got %0d required 4", rp_after); end
        total++;
        if (err_count !== 8'(model_err)) begin bad++; $display("FAIL basic_errs got %0d required %0d", err_count, model_err); end
    endtask

    task automatic test_backpressure();
        run_stream(0, 4, 2, 0);
        total++;
        if (obs_q.size() != 4) begin bad++; $display("FAIL bp_len got %0d required 4", obs_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            total++;
            if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL bp_word%0d got %h required %h", i, obs_q[i], exp_q[i]); end
        end
        total++;
        if (stalls != 3 || stall_bad != 0) begin bad++; $display("FAIL bp_hold got stalls=%0d unstable=%0d required 3 and 0", stalls, stall_bad); end
    endtask

    task automatic test_wrap();
        run_stream(30, 4, 1, 0);
        total++;
        if (obs_q.size() != 4) begin bad++; $display("FAIL wrap_len got %0d required 4", obs_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            total++;
            if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL wrap_word%0d got %h required %h", i, obs_q[i], exp_q[i]); end
        end
        total++;
        if (rp_after !== 5'd2) begin bad++; $display("FAIL wrap_rp got %0d required 2", rp_after); end
    endtask

    task automatic test_count_zero();
        run_stream(7, 0, 1, 0);
        total++;
        if (obs_q.size() != 0 || first_valid_k != -1) begin
            bad++; $display("FAIL zero_words got %0d words, first valid %0d required none", obs_q.size(), first_valid_k);
        end
        total++;
        if (done_k != 1) begin bad++; $display("FAIL zero_done got %0d required 1", done_k); end
        total++;
        if (rp_done !== 5'd7 || rp_after !== 5'd7) begin bad++; $display("FAIL zero_rp got %0d/%0d required 7", rp_done, rp_after); end
    endtask

    task automatic test_clamp();
        run_stream(3, 40, 0, 0);
        total++;
        if (obs_q.size() != DEPTH) begin bad++; $display("FAIL clamp_len got %0d required %0d", obs_q.size(), DEPTH); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            total++;
            if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL clamp_word%0d got %h required %h", i, obs_q[i], exp_q[i]); end
        end
        total++;
        if (last_xfer_k - first_xfer_k != DEPTH - 1) begin bad++; $display("FAIL back_to_back got span %0d required %0d", last_xfer_k - first_xfer_k, DEPTH - 1); end
    endtask

    task automatic test_start_ignored();
        run_stream(10, 6, 1, 1);
        total++;
        if (obs_q.size() != 6) begin bad++; $display("FAIL ign_len got %0d required 6", obs_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            total++;
            if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL ign_word%0d got %h required %h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_result_check();
        logic [2:0] exp_chk;
`ifdef RESULT_CHECK_EN
        exp_chk = 3'b100;
`else
        exp_chk = 3'b000;
`endif
        mem[12] = make_word(SUB, 10, 4, 7);
        mem[13] = make_word(DIV, 7, 0, 123);
        mem[14] = make_word(ADD, 2, 2, 4);
        run_stream(12, 3, 0, 0);
        total++;
        if (obs_q.size() != 3) begin
            bad++; $display("FAIL chk_len got %0d required 3", obs_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                total++;
                if (obs_q[i][0] !== exp_chk[2-i]) begin bad++; $display("FAIL chk_flag%0d got %b required %b", i, obs_q[i][0], exp_chk[2-i]); end
            end
        end
        total++;
        if (err_count !== 8'(model_err)) begin bad++; $display("FAIL chk_errs got %0d required %0d", err_count, model_err); end
    endtask

    task automatic test_reset_mid();
        int   k;
        logic seen1;
        out_ready = 1'b1;
        start_addr = '0;
        count = CNT_W'(4);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        seen1 = 1'b0;
        k = 0;
        while (!seen1 && k < 20) begin
            @(negedge clk);
            if (out_valid && out_index == 5'd1) seen1 = 1'b1;
            @(posedge clk); #1;
            k++;
        end
        total++;
        if (!seen1) begin bad++; $display("FAIL mid_seen got no index 1 required index 1 within 20 cycles"); end
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        model_err = 0;
        total++;
        if ({read_pointer, out_valid, out_index, busy, done, chk_err, err_count} !== '0 || out_instr !== '0) begin
            bad++;
            $display("FAIL mid_reset got rp=%0d v=%b idx=%0d busy=%b done=%b chk=%b errs=%0d instr=%h required all 0",
                     read_pointer, out_valid, out_index, busy, done, chk_err, err_count, out_instr);
        end
        @(posedge clk); #1;
        total++;
        if (done !== 1'b0) begin bad++; $display("FAIL mid_no_done got %b required 0", done); end
        reset_n = 1'b1;
        out_ready = 1'b0;
        @(posedge clk); #1;
        run_stream(5, 3, 1, 0);
        total++;
        if (obs_q.size() != 3) begin bad++; $display("FAIL mid_restart_len got %0d required 3", obs_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            total++;
            if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL mid_restart_word%0d got %h required %h", i, obs_q[i], exp_q[i]); end
        end
        total++;
        if (err_count !== 8'(model_err)) begin bad++; $display("FAIL mid_errs got %0d required %0d", err_count, model_err); end
    endtask

    task automatic test_random();
        int addr, cnt;
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < DEPTH; i++) mem[i] = rand_word();
            addr = $urandom_range(0, DEPTH - 1);
            cnt = $urandom_range(0, 40);
            run_stream(addr, cnt, 1, (cnt >= 4) && ($urandom_range(0, 1) == 1));
            total++;
            if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL rand%0d_len got %0d required %0d", r, obs_q.size(), exp_q.size()); end
            for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
                total++;
                if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL rand%0d_word%0d got %h required %h", r, i, obs_q[i], exp_q[i]); end
            end
            total++;
            if (err_count !== 8'(model_err)) begin bad++; $display("FAIL rand%0d_errs got %0d required %0d", r, err_count, model_err); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_wrap();
        test_count_zero();
        test_clamp();
        test_start_ignored();
        test_result_check();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
